// File: rtl/load_store_unit.sv
// Requester-side load/store bus initiator: lane placement, word-crossing split, load extension.
// One access in flight; req_ready drops from accept until the cycle after the response pulse.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t      state, state_nxt;
  logic        wr_q, err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, word0_q, word1_q;

  logic        accept, legal;
  logic [1:0]  off;
  logic [2:0]  size;
  logic [3:0]  mask;
  logic        split;
  logic [5:0]  sh0, sh1;
  logic [2:0]  rsh;
  logic [31:0] base_addr;
  logic [3:0]  be0, be1;
  logic [31:0] wdata0, wdata1;
  logic [63:0] dw;
  logic [31:0] load_val;
  logic        unused_bits;

  assign accept = (state == IDLE) && req_valid;

  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !req_write;
      default:                legal = 1'b0;
    endcase
  end

  // Access geometry, all derived from the latched request.
  assign off = addr_q[1:0];

  always_comb begin
    size = 3'd4;
    mask = 4'b1111;
    case (f3_q[1:0])
      2'b00:   begin size = 3'd1; mask = 4'b0001; end
      2'b01:   begin size = 3'd2; mask = 4'b0011; end
      default: begin size = 3'd4; mask = 4'b1111; end
    endcase
  end

  assign split     = ({1'b0, off} + size) > 3'd4;
  assign sh0       = {1'b0, off, 3'b000};
  assign sh1       = 6'd32 - sh0;
  assign rsh       = 3'd4 - {1'b0, off};
  assign base_addr = {addr_q[31:2], 2'b00};
  assign be0       = mask << off;
  assign be1       = mask >> rsh;
  assign wdata0    = wdata_q << sh0;
  assign wdata1    = wdata_q >> sh1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = legal ? REQ0 : RESP;
      REQ0:    if (mem_gnt) state_nxt = !wr_q ? WAIT0 : (split ? REQ1 : RESP);
      WAIT0:   if (mem_rvalid) state_nxt = split ? REQ1 : RESP;
      REQ1:    if (mem_gnt) state_nxt = wr_q ? RESP : WAIT1;
      WAIT1:   if (mem_rvalid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      word0_q <= 32'h0;
      word1_q <= 32'h0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wr_q    <= req_write;
        err_q   <= !legal;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        word0_q <= 32'h0;
        word1_q <= 32'h0;
      end
      if (state == WAIT0 && mem_rvalid) word0_q <= mem_rdata;
      if (state == WAIT1 && mem_rvalid) word1_q <= mem_rdata;
    end
  end

  // word1 stays zero for single-beat loads, so the same shift serves both cases.
  assign dw          = {word1_q, word0_q} >> sh0;
  assign unused_bits = ^dw[63:32];

  always_comb begin
    load_val = dw[31:0];
    case (f3_q)
      3'b000:  load_val = {{24{dw[7]}}, dw[7:0]};
      3'b001:  load_val = {{16{dw[15]}}, dw[15:0]};
      3'b100:  load_val = {24'h0, dw[7:0]};
      3'b101:  load_val = {16'h0, dw[15:0]};
      default: load_val = dw[31:0];
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'h0;
    mem_be     = 4'h0;
    mem_wdata  = 32'h0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    case (state)
      REQ0: begin
        mem_req   = 1'b1;
        mem_we    = wr_q;
        mem_addr  = base_addr;
        mem_be    = be0;
        mem_wdata = wdata0;
      end
      REQ1: begin
        mem_req   = 1'b1;
        mem_we    = wr_q;
        mem_addr  = base_addr + 32'd4;
        mem_be    = be1;
        mem_wdata = wdata1;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || wr_q) ? 32'h0 : load_val;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: stimulus queues expected beats/responses, a bus responder and a response monitor check them.
module tb_load_store_unit;
  timeunit 1ns;
  timeprecision 1ps;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [68:0] fields; int dly; } beat_t;
  typedef struct { logic err; logic [31:0] rdata; int lat; } resp_t;

  beat_t       beat_q[$];
  resp_t       resp_q[$];
  logic [31:0] rd_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  time         acc_time = 0;
  logic        hold_gnt = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_beat(input logic we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input int dly);
    beat_t b;
    b.fields = {we, a, be, wd};
    b.dly    = dly;
    beat_q.push_back(b);
  endtask

  // Bus responder: grants after the per-beat delay, returns read data the cycle after grant.
  initial begin
    logic [68:0] snap, cur;
    int          wait_cnt;
    logic        in_beat, rv_pend;
    beat_t       b;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    in_beat = 0; rv_pend = 0; wait_cnt = 0; snap = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 0;
      mem_rdata  = 0;
      mem_gnt    = 0;
      if (rv_pend) begin
        rv_pend    = 0;
        mem_rvalid = 1;
        if (rd_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rdata_underflow: read beat with no queued data at %0t", $time);
        end else mem_rdata = rd_q.pop_front();
      end
      if (mem_req) begin
        cur = {mem_we, mem_addr, mem_be, mem_wdata};
        if (!in_beat) begin
          in_beat  = 1;
          wait_cnt = 0;
          snap     = cur;
        end else chk("beat_hold", {3'b0, cur}, {3'b0, snap});
        if (!hold_gnt && (beat_q.size() == 0 || wait_cnt >= beat_q[0].dly)) begin
          mem_gnt = 1;
          in_beat = 0;
          if (beat_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_beat: got %0h expected none", cur);
          end else begin
            b = beat_q.pop_front();
            chk("beat", {3'b0, cur}, {3'b0, b.fields});
          end
          if (!mem_we) rv_pend = 1;
        end else wait_cnt++;
      end else in_beat = 0;
    end
  end

  // Response monitor plus idle-output checks.
  initial begin
    resp_t e;
    int    lat;
    forever begin
      @(negedge clk);
      if (!mem_req) chk("mem_idle_zero", {3'b0, mem_we, mem_addr, mem_be, mem_wdata}, 72'h0);
      if (resp_valid) begin
        lat = int'(($time - acc_time + 5) / 10);
        if (resp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_resp: got err=%0b rdata=%0h expected none", resp_err, resp_rdata);
        end else begin
          e = resp_q.pop_front();
          chk("resp_err", {71'h0, resp_err}, {71'h0, e.err});
          chk("resp_rdata", {40'h0, resp_rdata}, {40'h0, e.rdata});
          chk("resp_latency", 72'(lat), 72'(e.lat));
        end
      end else chk("resp_idle_zero", {39'h0, resp_err, resp_rdata}, 72'h0);
    end
  end

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic err, input logic [31:0] rd, input int lat);
    resp_t r;
    int    n;
    r.err = err; r.rdata = rd; r.lat = lat;
    resp_q.push_back(r);
    req_valid = 1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    acc_time = $time;
    #1;
    req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    @(negedge clk);
    chk("ready_busy", {71'h0, req_ready}, 72'h0);
    n = 0;
    while (!resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) chk("resp_timeout", {71'h0, resp_valid}, 72'h1);
    @(negedge clk);
    chk("ready_after_resp", {71'h0, req_ready}, 72'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    repeat (2) @(negedge clk);
    chk("reset_ready", {71'h0, req_ready}, 72'h1);
    chk("reset_outputs", {mem_req, mem_we, resp_valid, resp_err, resp_rdata, mem_be}, 72'h0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    // SB 0x103: single beat in lane 3
    exp_beat(1, 32'h100, 4'b1000, 32'hA500_0000, 0);
    issue(1, 3'b000, 32'h103, 32'h0000_00A5, 0, 32'h0, 2);

    // Reset while a beat is waiting for grant
    hold_gnt = 1;
    req_valid = 1; req_write = 0; req_funct3 = 3'b010; req_addr = 32'h300; req_wdata = 0;
    @(posedge clk); #1 req_valid = 0;
    repeat (3) @(negedge clk);
    chk("pre_reset_req", {71'h0, mem_req}, 72'h1);
    rst_n = 0;
    #1;
    chk("mid_reset_req", {71'h0, mem_req}, 72'h0);
    chk("mid_reset_resp", {71'h0, resp_valid}, 72'h0);
    chk("mid_reset_ready", {71'h0, req_ready}, 72'h1);
    @(posedge clk); #1 rst_n = 1; hold_gnt = 0;
    @(posedge clk); #1;
    exp_beat(0, 32'h300, 4'b1111, 32'h0, 0);
    rd_q.push_back(32'h1234_5678);
    issue(0, 3'b010, 32'h300, 32'h0, 0, 32'h1234_5678, 3);

    // LH / LHU 0x102
    exp_beat(0, 32'h100, 4'b1100, 32'h0, 0);
    rd_q.push_back(32'h8001_1234);
    issue(0, 3'b001, 32'h102, 32'h0, 0, 32'hFFFF_8001, 3);
    exp_beat(0, 32'h100, 4'b1100, 32'h0, 0);
    rd_q.push_back(32'h8001_1234);
    issue(0, 3'b101, 32'h102, 32'h0, 0, 32'h0000_8001, 3);

    // SW 0x101 split
    exp_beat(1, 32'h100, 4'b1110, 32'hCCBB_AA00, 0);
    exp_beat(1, 32'h104, 4'b0001, 32'h0000_00DD, 0);
    issue(1, 3'b010, 32'h101, 32'hDDCC_BBAA, 0, 32'h0, 3);

    // LW 0x103 split, beat 0 grant delayed 3 cycles
    exp_beat(0, 32'h100, 4'b1000, 32'h0, 3);
    exp_beat(0, 32'h104, 4'b0111, 32'h0, 0);
    rd_q.push_back(32'h4400_0000);
    rd_q.push_back(32'h0033_2211);
    issue(0, 3'b010, 32'h103, 32'h0, 0, 32'h3322_1144, 8);

    // Illegal load funct3: no beat, error response
    issue(0, 3'b011, 32'h200, 32'h0, 1, 32'h0, 1);
    // Illegal store funct3 (BU is load-only)
    issue(1, 3'b100, 32'h204, 32'h1234_5678, 1, 32'h0, 1);

    // LB 0x101 negative byte, LBU 0x100
    exp_beat(0, 32'h100, 4'b0010, 32'h0, 0);
    rd_q.push_back(32'h0000_8000);
    issue(0, 3'b000, 32'h101, 32'h0, 0, 32'hFFFF_FF80, 3);
    exp_beat(0, 32'h100, 4'b0001, 32'h0, 0);
    rd_q.push_back(32'h0000_00F0);
    issue(0, 3'b100, 32'h100, 32'h0, 0, 32'h0000_00F0, 3);

    // SH 0x103 split halfword
    exp_beat(1, 32'h100, 4'b1000, 32'hEF00_0000, 0);
    exp_beat(1, 32'h104, 4'b0001, 32'h0000_00BE, 0);
    issue(1, 3'b001, 32'h103, 32'h0000_BEEF, 0, 32'h0, 3);

    // LW wrapping past the top of the address space
    exp_beat(0, 32'hFFFF_FFFC, 4'b1100, 32'h0, 0);
    exp_beat(0, 32'h0000_0000, 4'b0011, 32'h0, 0);
    rd_q.push_back(32'hBBAA_0000);
    rd_q.push_back(32'h0000_DDCC);
    issue(0, 3'b010, 32'hFFFF_FFFE, 32'h0, 0, 32'hDDCC_BBAA, 5);

    repeat (3) @(negedge clk);
    chk("beat_q_drained", 72'(beat_q.size()), 72'h0);
    chk("resp_q_drained", 72'(resp_q.size()), 72'h0);
    chk("rd_q_drained", 72'(rd_q.size()), 72'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Bus initiator between the CPU memory stage and the data memory / MMIO bus. It accepts one load or store per handshake and drives a word-addressed request/grant memory port with byte enables. It splits word-boundary-crossing accesses into two bus beats and returns load data extracted and sign- or zero-extended. It is the requester-side counterpart of the data memory: all lane placement and extension happen here, not in the memory.

## Interface
- No parameters. Address and data are fixed at 32 bits.
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  CPU access request
- req_ready  out  1  unit idle, request accepted when valid&ready
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address, any alignment
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse, no backpressure
- resp_err  out  1  illegal funct3, valid with resp_valid
- resp_rdata  out  32  extended load data, valid with resp_valid
- mem_req  out  1  bus beat request, held until mem_gnt
- mem_we  out  1  beat is a write
- mem_addr  out  32  word-aligned byte address, [1:0]=00
- mem_be  out  4  byte lane enables, bit i = bits [8i+7:8i]
- mem_wdata  out  32  lane-positioned write data
- mem_gnt  in  1  beat accepted this cycle (write completes here)
- mem_rvalid  in  1  read data valid, at least 1 cycle after its gnt
- mem_rdata  in  32  read word

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: req_ready=1. On accept, latch write, funct3, addr, and wdata.
  - Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010.
  - Illegal funct3: go to RESP with err=1 and issue no bus beat.
  - Legal funct3: go to REQ0.
- Size n = 1/2/4 bytes, off = addr[1:0]. Split when off+n > 4. Misaligned halfword (off=3) and misaligned word (off=1..3) are supported.
- Beat 0 lanes:
  - mem_addr = {addr[31:2],00}.
  - mem_be = ((1<<n)-1) << off, truncated to 4 bits.
  - mem_wdata = wdata << 8·off.
- Beat 1 lanes (split only):
  - mem_addr = beat0 address + 4, wrapping modulo 2^32.
  - mem_be = ((1<<n)-1) >> (4-off).
  - mem_wdata = wdata >> 8·(4-off).
- REQ0/REQ1 behaviour:
  - mem_req=1, with addr, be, we, and wdata stable until mem_gnt.
  - On gnt for a write: go to REQ1 if split and in beat 0, else RESP.
  - On gnt for a read: go to WAIT0/WAIT1.
- WAIT0/WAIT1 behaviour:
  - On mem_rvalid, capture mem_rdata as word0/word1.
  - Then go to REQ1 if split and in beat 0, else RESP.
- Load result:
  - Form a 64-bit value {word1,word0} (word1 = 0 if not split) and shift it right by 8·off.
  - Take the low n bytes. Sign-extend for funct3 000/001, zero-extend for 100/101; 010 passes the word through.
- RESP: resp_valid=1 for one cycle, then IDLE.
  - resp_rdata is 0 for stores and for errors.
- mem_rvalid or mem_gnt outside the states that expect them is ignored.
- When mem_req=0: mem_we, mem_be, mem_addr, and mem_wdata drive 0.
- When resp_valid=0: resp_err and resp_rdata drive 0.

## Timing
- Reset: state IDLE, req_ready=1. All other outputs are 0 and all latched registers are 0.
- Reset asserted mid-access forces IDLE immediately. A read response arriving after reset is ignored.
- Latency, counted from the accept edge t0 with zero-wait gnt and rvalid at gnt+1:
  - Aligned store: beat at t1, resp_valid at t2.
  - Aligned load: beat at t1, rvalid at t2, resp_valid at t3.
  - Split store: resp_valid at t3.
  - Split load: resp_valid at t5.
  - Illegal funct3: resp_valid at t1.
- Each gnt wait cycle and each extra rvalid wait cycle adds one cycle.
- req_ready is 0 from t1 through the RESP cycle, and returns to 1 the cycle after RESP.
- Only one access is outstanding at a time, and only one beat per access is outstanding at a time.

## Test plan
- Reset: assert rst_n=0 mid-REQ0 with gnt withheld -> mem_req=0, resp_valid=0, req_ready=1 immediately. After release, a fresh LW completes normally.
- SB addr 0x103, wdata 0x000000A5, gnt immediate:
  - Single beat with mem_addr 0x100, be 1000, wdata 0xA5000000, we=1.
  - resp_valid at t2 with err=0.
- LH / LHU at addr 0x102, rdata 0x8001_1234:
  - LH -> resp_rdata 0xFFFF8001.
  - LHU -> 0x00008001.
  - Both use be 1100.
- SW addr 0x101, wdata 0xDDCCBBAA:
  - Beat 0: addr 0x100, be 1110, wdata 0xCCBBAA00.
  - Beat 1: addr 0x104, be 0001, wdata 0x000000DD.
  - Exactly one resp_valid.
- LW addr 0x103, word0 0x44000000, word1 0x00332211, gnt delayed 3 cycles on beat 0:
  - mem_req and mem_addr are held stable through the delay.
  - resp_rdata = 0x33221144.
- Load with funct3 011 at 0x200 -> mem_req never asserts; resp_valid at t1 with resp_err=1 and rdata 0.
